fifo_burst_reader: RTL and testbench

- Drains a first-word-fall-through FIFO read port (valid/read handshake) and emits fixed-length data bursts toward the PCIe TX engine.
- Uses host-granted credit to gate bursts.
- Requests an arbiter slot before each burst, then streams exactly BURST words through a registered output stage with o_ready backpressure.
- Sits between the FPGA-to-host FIFO output and the TLP write builder, in the same clock domain as the FIFO read side.

---
 rtl/hififo_pkg.sv | 10 +
 rtl/fifo_burst_credit.sv | 29 ++
 rtl/fifo_burst_reader.sv | 88 ++++++++
 tb/tb_fifo_burst_reader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hififo_pkg.sv
// hififo_pkg: burst-reader state encoding and default sizing shared by the reader and its credit counter.
package hififo_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_BURST = 2'd2
   } state_t;
   localparam int DEF_BURST = 16;
   localparam int DEF_CBITS = 24;
endpackage

// File: rtl/fifo_burst_credit.sv
// fifo_burst_credit: saturating host-credit counter; adds granted words and subtracts one burst per grant in the same cycle.
module fifo_burst_credit
   import hififo_pkg::*;
#(
   parameter int BURST = DEF_BURST,
   parameter int CBITS = DEF_CBITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_add,
   input  logic [15:0]      i_words,
   input  logic             i_take,
   output logic [CBITS-1:0] o_credit,
   output logic             o_ge_burst
);
   // one spare bit above the wider operand so the sum can be seen overflowing before clamping
   localparam int SW = (CBITS > 16 ? CBITS : 16) + 1;
   localparam logic [SW-1:0] L_BURST = SW'(BURST);
   localparam logic [SW-1:0] L_MAX   = SW'({CBITS{1'b1}});
   logic [SW-1:0] w_sum;
   logic          w_take;
   assign o_ge_burst = o_credit >= CBITS'(BURST);
   assign w_take     = i_take && o_ge_burst;
   always_comb w_sum = SW'(o_credit) + (i_add ? SW'(i_words) : '0) - (w_take ? L_BURST : '0);
   always_ff @(posedge clock) begin
      if (reset) o_credit <= '0;
      else       o_credit <= w_sum > L_MAX ? L_MAX[CBITS-1:0] : w_sum[CBITS-1:0];
   end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains an FWFT FIFO into credit-gated, arbiter-granted fixed-length bursts
// through a single registered output stage with downstream backpressure.
module fifo_burst_reader
   import hififo_pkg::*;
#(
   parameter int NBITS = 64,
   parameter int BURST = DEF_BURST,
   parameter int CBITS = DEF_CBITS
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             credit_add,
   input  logic [15:0]      credit_words,
   input  logic [NBITS-1:0] f_data,
   input  logic             f_valid,
   input  logic             f_almost_empty,
   output logic             f_read,
   output logic             o_req,
   input  logic             o_gnt,
   output logic [NBITS-1:0] o_data,
   output logic             o_valid,
   output logic             o_last,
   input  logic             o_ready,
   output logic [CBITS-1:0] credit,
   output logic [31:0]      words_sent
);
   localparam int IW = $clog2(BURST + 1);
   localparam logic [IW-1:0] L_BURST = IW'(BURST);
   state_t        r_state;
   logic [IW-1:0] r_issued;
   logic          w_take;
   logic          w_accept;
   logic          w_ge_burst;
   assign w_take   = (r_state == ST_REQ) && o_gnt;
   assign w_accept = o_valid && o_ready;
   // pop only while the output slot is free or being emptied this cycle
   assign f_read   = (r_state == ST_BURST) && f_valid && (r_issued < L_BURST) && (!o_valid || o_ready);
   fifo_burst_credit #(.BURST(BURST), .CBITS(CBITS)) u_credit (
      .clock      (clock),
      .reset      (reset),
      .i_add      (credit_add),
      .i_words    (credit_words),
      .i_take     (w_take),
      .o_credit   (credit),
      .o_ge_burst (w_ge_burst)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_issued   <= '0;
         o_req      <= 1'b0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_last     <= 1'b0;
         words_sent <= '0;
      end else begin
         if (w_accept) words_sent <= words_sent + 32'd1;
         case (r_state)
            ST_IDLE: if (enable && !f_almost_empty && w_ge_burst) begin
               r_state <= ST_REQ;
               o_req   <= 1'b1;
            end
            ST_REQ: if (o_gnt) begin
               r_state  <= ST_BURST;
               o_req    <= 1'b0;
               r_issued <= '0;
            end else if (!enable) begin
               r_state <= ST_IDLE;
               o_req   <= 1'b0;
            end
            ST_BURST: begin
               if (f_read) begin
                  o_data   <= f_data;
                  o_valid  <= 1'b1;
                  o_last   <= r_issued == L_BURST - 1'b1;
                  r_issued <= r_issued + 1'b1;
               end else if (w_accept) begin
                  o_valid <= 1'b0;
                  o_last  <= 1'b0;
               end
               if (w_accept && o_last) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with an FWFT FIFO model, optional auto-grant arbiter and an output monitor.
module tb_fifo_burst_reader;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        credit_add = 1'b0;
   logic [15:0] credit_words = '0;
   logic [63:0] f_data;
   logic        f_valid;
   logic        f_almost_empty;
   logic        f_read;
   logic        o_req;
   logic        o_gnt;
   logic [63:0] o_data;
   logic        o_valid;
   logic        o_last;
   logic        o_ready = 1'b1;
   logic [23:0] credit;
   logic [31:0] words_sent;
   logic [63:0] mem [256];
   int          rd_ptr = 0;
   int          wr_ptr = 0;
   logic        stall = 1'b0;
   logic        auto_gnt = 1'b0;
   logic        man_gnt = 1'b0;
   int          req_age = 0;
   int          n_acc = 0;
   int          n_rd = 0;
   int          n_last = 0;
   logic [63:0] acc_data [256];
   logic        acc_last [256];
   int          n_checks = 0;
   int          n_err = 0;
   fifo_burst_reader #(.NBITS(64), .BURST(16), .CBITS(24)) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .credit_add     (credit_add),
      .credit_words   (credit_words),
      .f_data         (f_data),
      .f_valid        (f_valid),
      .f_almost_empty (f_almost_empty),
      .f_read         (f_read),
      .o_req          (o_req),
      .o_gnt          (o_gnt),
      .o_data         (o_data),
      .o_valid        (o_valid),
      .o_last         (o_last),
      .o_ready        (o_ready),
      .credit         (credit),
      .words_sent     (words_sent)
   );
   always #5 clock = ~clock;
   assign f_data         = mem[rd_ptr[7:0]];
   assign f_valid        = (wr_ptr != rd_ptr) && !stall;
   assign f_almost_empty = (wr_ptr - rd_ptr) < 16;
   assign o_gnt          = man_gnt || (auto_gnt && o_req && req_age >= 2);
   always @(posedge clock) begin
      req_age <= o_req ? req_age + 1 : 0;
      if (f_read) begin
         rd_ptr <= rd_ptr + 1;
         n_rd   <= n_rd + 1;
      end
      if (!reset && o_valid && o_ready) begin
         acc_data[n_acc[7:0]] <= o_data;
         acc_last[n_acc[7:0]] <= o_last;
         n_acc <= n_acc + 1;
         if (o_last) n_last <= n_last + 1;
      end
   end
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic count_bad(input int a0, input int r0, input int n, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) if (acc_data[a0 + i] !== mem[r0 + i]) bad++;
   endtask
   initial begin
      int a0, r0, lc, bad, hold_bad, bub;
      logic v, r;
      logic [63:0] d;
      for (int i = 0; i < 256; i++) mem[i] = 64'h1234_0000_0000_0000 + 64'(i) * 64'h0001_0003_0005_0007;
      tick();
      tick();
      reset = 1'b0;
      check("rst_o_req", o_req, 0);
      check("rst_o_valid", o_valid, 0);
      check("rst_o_last", o_last, 0);
      check("rst_f_read", f_read, 0);
      check("rst_o_data", o_data, 0);
      check("rst_credit", credit, 0);
      check("rst_words_sent", words_sent, 0);
      // two full bursts from 40 queued words and 32 words of credit
      wr_ptr = 40;
      enable = 1'b1;
      auto_gnt = 1'b1;
      credit_add = 1'b1;
      credit_words = 16'd32;
      tick();
      credit_add = 1'b0;
      check("t1_credit_add", credit, 32);
      for (int k = 0; k < 200 && n_acc < 32; k++) tick();
      repeat (10) tick();
      check("t1_words", n_acc, 32);
      check("t1_lasts", n_last, 2);
      check("t1_last16", acc_last[15], 1);
      check("t1_last32", acc_last[31], 1);
      check("t1_pops", n_rd, 32);
      count_bad(0, 0, 32, bad);
      check("t1_data", bad, 0);
      check("t1_credit_end", credit, 0);
      check("t1_words_sent", words_sent, 32);
      check("t1_no_third_req", o_req, 0);
      // credit present but FIFO almost empty
      wr_ptr = rd_ptr;
      credit_add = 1'b1;
      credit_words = 16'd16;
      tick();
      credit_add = 1'b0;
      check("t2_credit", credit, 16);
      repeat (3) tick();
      check("t2_req_blocked", o_req, 0);
      wr_ptr = wr_ptr + 20;
      tick();
      check("t2_req_rises", o_req, 1);
      // o_ready toggling every cycle through a burst
      a0 = n_acc;
      r0 = rd_ptr;
      lc = n_rd;
      hold_bad = 0;
      for (int k = 0; k < 200 && n_acc < 48; k++) begin
         o_ready = !o_ready;
         v = o_valid;
         r = o_ready;
         d = o_data;
         tick();
         if (v && !r && (o_valid !== 1'b1 || o_data !== d)) hold_bad++;
      end
      o_ready = 1'b1;
      repeat (3) tick();
      check("t3_words", n_acc, 48);
      check("t3_pops", n_rd - lc, 16);
      check("t3_hold", hold_bad, 0);
      count_bad(a0, r0, 16, bad);
      check("t3_data", bad, 0);
      check("t3_last", acc_last[47], 1);
      check("t3_lasts", n_last, 3);
      check("t3_words_sent", words_sent, 48);
      // FIFO runs dry for three cycles mid-burst
      a0 = n_acc;
      r0 = rd_ptr;
      wr_ptr = wr_ptr + 16;
      credit_add = 1'b1;
      credit_words = 16'd16;
      tick();
      credit_add = 1'b0;
      for (int k = 0; k < 60 && n_acc < 53; k++) tick();
      bub = 0;
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (!o_valid && n_acc < 64) bub++;
      end
      stall = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (n_acc >= 64) break;
         if (!o_valid) bub++;
      end
      check("t4_words", n_acc, 64);
      check("t4_bubbles", bub, 3);
      count_bad(a0, r0, 16, bad);
      check("t4_data", bad, 0);
      check("t4_last", acc_last[63], 1);
      check("t4_lasts", n_last, 4);
      check("t4_words_sent", words_sent, 64);
      // credit saturation
      enable = 1'b0;
      credit_add = 1'b1;
      credit_words = 16'hFFFF;
      repeat (256) tick();
      credit_words = 16'd246;
      tick();
      credit_add = 1'b0;
      check("t5_near_max", credit, 24'hFFFFF6);
      credit_add = 1'b1;
      credit_words = 16'd100;
      tick();
      credit_add = 1'b0;
      check("t5_saturate", credit, 24'hFFFFFF);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_reset_credit", credit, 0);
      // add of 5 coinciding with a grant from credit 16
      auto_gnt = 1'b0;
      wr_ptr = wr_ptr + 20;
      enable = 1'b1;
      credit_add = 1'b1;
      credit_words = 16'd16;
      tick();
      credit_add = 1'b0;
      for (int k = 0; k < 10 && !o_req; k++) tick();
      check("t5_req", o_req, 1);
      lc = n_last;
      man_gnt = 1'b1;
      credit_add = 1'b1;
      credit_words = 16'd5;
      tick();
      man_gnt = 1'b0;
      credit_add = 1'b0;
      check("t5_add_and_take", credit, 5);
      check("t5_req_drop", o_req, 0);
      for (int k = 0; k < 60 && n_last == lc; k++) tick();
      check("t5_burst_done", n_last, lc + 1);
      // enable dropped while waiting for grant
      wr_ptr = wr_ptr + 20;
      credit_add = 1'b1;
      credit_words = 16'd11;
      tick();
      credit_add = 1'b0;
      check("t6_credit", credit, 16);
      for (int k = 0; k < 10 && !o_req; k++) tick();
      check("t6_req", o_req, 1);
      r0 = n_rd;
      enable = 1'b0;
      tick();
      check("t6_req_drop", o_req, 0);
      repeat (3) tick();
      check("t6_req_stays", o_req, 0);
      check("t6_no_pop", n_rd - r0, 0);
      check("t6_credit_kept", credit, 16);
      // reset at beat 7 of a burst
      auto_gnt = 1'b1;
      enable = 1'b1;
      r0 = n_rd;
      lc = n_last;
      for (int k = 0; k < 60 && (n_rd - r0) < 7; k++) tick();
      check("t7_beat7", n_rd - r0, 7);
      reset = 1'b1;
      tick();
      check("t7_o_valid", o_valid, 0);
      check("t7_o_last", o_last, 0);
      check("t7_o_req", o_req, 0);
      check("t7_o_data", o_data, 0);
      check("t7_f_read", f_read, 0);
      check("t7_credit", credit, 0);
      check("t7_words_sent", words_sent, 0);
      reset = 1'b0;
      enable = 1'b0;
      repeat (3) tick();
      check("t7_no_last", n_last, lc);
      check("t7_idle_req", o_req, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
